// File: rtl/diff_demo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : diff_demo_pkg
// Description : Shared configuration constants and types for the diff core
//               and its load stage.
// Revision    : 1.0 - initial release
// ============================================================================
package diff_demo_pkg;

    // Core geometry
    localparam int CONF_PE_COL          = 4;
    localparam int CONF_FM_BUF_DEPTH    = 64;
    localparam int CONF_GUARD_BUF_DEPTH = 32;

    // Width of one buffer word
    localparam int LD_DATA_W = 72;

    // Load stage controller states
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } load_state_e;

    // Load command target select
    localparam logic LD_TGT_FM = 1'b0;
    localparam logic LD_TGT_GD = 1'b1;

    // Larger of two widths
    function automatic int ld_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_col_decoder.sv
`default_nettype none
// ============================================================================
// Module      : load_col_decoder
// Description : Maps the current column / active column count to a per-column
//               write enable vector: one-hot for sequential loads, thermometer
//               (columns 0..col_num-1) for broadcast loads.
// Revision    : 1.0 - initial release
// ============================================================================
module load_col_decoder
    import diff_demo_pkg::*;
#(
    parameter int NUM_COL = CONF_PE_COL,
    parameter int CCW     = 2,
    parameter int CNW     = 3
) (
    input  logic [CCW-1:0]     col_cnt,
    input  logic [CNW-1:0]     col_num,
    input  logic               bcast,
    input  logic               fire,
    output logic [NUM_COL-1:0] col_en
);

    genvar i;
    generate
        for (i = 0; i < NUM_COL; i++) begin : g_col
            // Column i is written on a handshake when it is the current
            // column, or when broadcasting and it lies below the active count.
            assign col_en[i] = fire & (bcast ? (CNW'(i) < col_num)
                                             : (CCW'(i) == col_cnt));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/diff_fm_loader.sv
`default_nettype none
// ============================================================================
// Module      : diff_fm_loader
// Description : Load stage for the diff core. Accepts a load command and a
//               72-bit word stream, scatters words into the per-column FM or
//               guard buffer write ports (sequential or broadcast), and pulses
//               load_done when the command completes.
// Revision    : 1.0 - initial release
// ============================================================================
module diff_fm_loader
    import diff_demo_pkg::*;
#(
    parameter  int NUM_COL  = CONF_PE_COL,
    parameter  int FM_DEPTH = CONF_FM_BUF_DEPTH,
    parameter  int GD_DEPTH = CONF_GUARD_BUF_DEPTH,
    localparam int FAW      = $clog2(FM_DEPTH),
    localparam int GAW      = $clog2(GD_DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_target,
    input  logic                              cmd_bcast,
    input  logic [7:0]                        cmd_col_num,
    input  logic [15:0]                       cmd_base,
    input  logic [15:0]                       cmd_words,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [LD_DATA_W-1:0]              s_data,
    output logic [NUM_COL-1:0][FAW-1:0]       load_fm_wr_addr,
    output logic [NUM_COL-1:0][LD_DATA_W-1:0] load_fm_din,
    output logic [NUM_COL-1:0]                load_fm_wr_en,
    output logic [NUM_COL-1:0][GAW-1:0]       load_gd_wr_addr,
    output logic [NUM_COL-1:0][LD_DATA_W-1:0] load_gd_din,
    output logic [NUM_COL-1:0]                load_gd_wr_en,
    output logic                              load_busy,
    output logic                              load_done
);

    // Shared running address wide enough for either buffer
    localparam int AW  = ld_max(FAW, GAW);
    localparam int CCW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam int CNW = $clog2(NUM_COL + 1);

    load_state_e        state_q;
    load_state_e        state_d;

    logic               tgt_q;
    logic               bcast_q;
    logic [CNW-1:0]     col_num_q;
    logic [15:0]        words_q;
    logic [AW-1:0]      base_q;
    logic [AW-1:0]      addr_q;
    logic [15:0]        word_cnt_q;
    logic [CCW-1:0]     col_cnt_q;

    logic               cmd_fire;
    logic               fire;
    logic               cmd_zero;
    logic               last_word;
    logic               last_col;
    logic [CNW-1:0]     col_num_clamped;
    logic [NUM_COL-1:0] col_en;
    logic               unused_base;

    // Handshakes are qualified by the registered state, never by the
    // combinational ready outputs, so no path exists from valid to ready.
    assign cmd_fire  = cmd_valid & (state_q == LD_IDLE);
    assign fire      = s_valid & (state_q == LD_LOAD);

    // Zero check uses the raw column count; clamping happens afterwards.
    assign cmd_zero        = (cmd_words == 16'd0) || (cmd_col_num == 8'd0);
    assign col_num_clamped = (cmd_col_num > 8'(NUM_COL)) ? CNW'(NUM_COL)
                                                         : CNW'(cmd_col_num);

    assign last_word = (word_cnt_q == (words_q - 16'd1));
    assign last_col  = ((int'(col_cnt_q) + 1) == int'(col_num_q));

    // Base bits above the address width are dropped by design.
    assign unused_base = ^(cmd_base >> AW);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/status outputs
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        load_busy = 1'b1;
        load_done = 1'b0;
        case (state_q)
            LD_IDLE: begin
                cmd_ready = 1'b1;
                load_busy = 1'b0;
                if (cmd_valid) begin
                    state_d = cmd_zero ? LD_DONE : LD_LOAD;
                end
            end
            LD_LOAD: begin
                s_ready = 1'b1;
                if (fire && last_word && (bcast_q || last_col)) begin
                    state_d = LD_DONE;
                end
            end
            LD_DONE: begin
                load_done = 1'b1;
                state_d   = LD_IDLE;
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    // Command latch and word/column/address counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt_q      <= LD_TGT_FM;
            bcast_q    <= 1'b0;
            col_num_q  <= '0;
            words_q    <= '0;
            base_q     <= '0;
            addr_q     <= '0;
            word_cnt_q <= '0;
            col_cnt_q  <= '0;
        end else if (cmd_fire) begin
            tgt_q      <= cmd_target;
            bcast_q    <= cmd_bcast;
            col_num_q  <= col_num_clamped;
            words_q    <= cmd_words;
            base_q     <= cmd_base[AW-1:0];
            addr_q     <= cmd_base[AW-1:0];
            word_cnt_q <= '0;
            col_cnt_q  <= '0;
        end else if (fire) begin
            if (last_word && !bcast_q && !last_col) begin
                // Column finished: restart the address for the next column
                word_cnt_q <= '0;
                addr_q     <= base_q;
                col_cnt_q  <= col_cnt_q + CCW'(1);
            end else begin
                word_cnt_q <= word_cnt_q + 16'd1;
                addr_q     <= addr_q + AW'(1);
            end
        end
    end

    load_col_decoder #(
        .NUM_COL (NUM_COL),
        .CCW     (CCW),
        .CNW     (CNW)
    ) u_col_decoder (
        .col_cnt (col_cnt_q),
        .col_num (col_num_q),
        .bcast   (bcast_q),
        .fire    (fire),
        .col_en  (col_en)
    );

    // Registered buffer write ports; address/data hold when not written
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_fm_wr_en   <= '0;
            load_gd_wr_en   <= '0;
            load_fm_wr_addr <= '0;
            load_gd_wr_addr <= '0;
            load_fm_din     <= '0;
            load_gd_din     <= '0;
        end else begin
            load_fm_wr_en <= (tgt_q == LD_TGT_FM) ? col_en : '0;
            load_gd_wr_en <= (tgt_q == LD_TGT_GD) ? col_en : '0;
            for (int c = 0; c < NUM_COL; c++) begin
                if (col_en[c]) begin
                    if (tgt_q == LD_TGT_FM) begin
                        load_fm_wr_addr[c] <= addr_q[FAW-1:0];
                        load_fm_din[c]     <= s_data;
                    end else begin
                        load_gd_wr_addr[c] <= addr_q[GAW-1:0];
                        load_gd_din[c]     <= s_data;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_diff_fm_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_diff_fm_loader
// Description : Self-checking bench for diff_fm_loader. A command-level model
//               expands each load into the list of expected buffer writes;
//               observed writes and done pulses are compared cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_diff_fm_loader;
    import diff_demo_pkg::*;

    localparam int NUM_COL  = CONF_PE_COL;
    localparam int FM_DEPTH = CONF_FM_BUF_DEPTH;
    localparam int GD_DEPTH = CONF_GUARD_BUF_DEPTH;
    localparam int FAW      = $clog2(FM_DEPTH);
    localparam int GAW      = $clog2(GD_DEPTH);

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_target;
    logic                        cmd_bcast;
    logic [7:0]                  cmd_col_num;
    logic [15:0]                 cmd_base;
    logic [15:0]                 cmd_words;
    logic                        s_valid;
    logic                        s_ready;
    logic [71:0]                 s_data;
    logic [NUM_COL-1:0][FAW-1:0] load_fm_wr_addr;
    logic [NUM_COL-1:0][71:0]    load_fm_din;
    logic [NUM_COL-1:0]          load_fm_wr_en;
    logic [NUM_COL-1:0][GAW-1:0] load_gd_wr_addr;
    logic [NUM_COL-1:0][71:0]    load_gd_din;
    logic [NUM_COL-1:0]          load_gd_wr_en;
    logic                        load_busy;
    logic                        load_done;

    diff_fm_loader #(
        .NUM_COL  (NUM_COL),
        .FM_DEPTH (FM_DEPTH),
        .GD_DEPTH (GD_DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_target      (cmd_target),
        .cmd_bcast       (cmd_bcast),
        .cmd_col_num     (cmd_col_num),
        .cmd_base        (cmd_base),
        .cmd_words       (cmd_words),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .load_fm_wr_addr (load_fm_wr_addr),
        .load_fm_din     (load_fm_din),
        .load_fm_wr_en   (load_fm_wr_en),
        .load_gd_wr_addr (load_gd_wr_addr),
        .load_gd_din     (load_gd_din),
        .load_gd_wr_en   (load_gd_wr_en),
        .load_busy       (load_busy),
        .load_done       (load_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                 tgt;
        logic [NUM_COL-1:0] mask;
        int                 addr;
        logic [71:0]        data;
    } wr_t;

    typedef struct {
        bit          tgt;
        bit          bcast;
        logic [7:0]  cn;
        logic [15:0] base;
        logic [15:0] words;
        int          gap;
        int          exp_wr;
    } vec_t;

    wr_t         exp_q[$];
    logic [71:0] data_q[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_cycles;
    int          model_n;
    bit          in_cmd = 0;
    bit          zero_len_due = 0;
    bit          done_seen = 0;
    vec_t        tbl[10];

    // Expand a command into the expected writes and the data to send
    task automatic build_model(input bit tgt, input bit bc, input logic [7:0] cn,
                               input logic [15:0] base, input logic [15:0] words);
        int ecol;
        int depth;
        wr_t e;
        logic [71:0] d;
        exp_q.delete();
        data_q.delete();
        ecol  = (int'(cn) > NUM_COL) ? NUM_COL : int'(cn);
        depth = tgt ? GD_DEPTH : FM_DEPTH;
        if (words != 0 && cn != 0) begin
            for (int c = 0; c < (bc ? 1 : ecol); c++) begin
                for (int w = 0; w < int'(words); w++) begin
                    d      = {8'($urandom), $urandom, $urandom};
                    e.tgt  = tgt;
                    e.mask = bc ? NUM_COL'((1 << ecol) - 1) : NUM_COL'(1 << c);
                    e.addr = (int'(base) + w) % depth;
                    e.data = d;
                    data_q.push_back(d);
                    exp_q.push_back(e);
                end
            end
        end
        model_n = exp_q.size();
    endtask

    // Compare this cycle's write ports and done pulse against the model
    task automatic check_cycle();
        bit                 wrote;
        bit                 t;
        bit                 ok;
        bit                 exp_done;
        logic [NUM_COL-1:0] m;
        wr_t                e;
        wrote = (|load_fm_wr_en) || (|load_gd_wr_en);
        if (wrote) begin
            wr_cycles++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: fm_wr_en=%b gd_wr_en=%b, required no write",
                         load_fm_wr_en, load_gd_wr_en);
            end else begin
                e  = exp_q.pop_front();
                t  = |load_gd_wr_en;
                m  = t ? load_gd_wr_en : load_fm_wr_en;
                ok = (t == e.tgt) && (m == e.mask) && !((|load_fm_wr_en) && (|load_gd_wr_en));
                for (int c = 0; c < NUM_COL; c++) begin
                    if (e.mask[c]) begin
                        if (e.tgt) begin
                            if (int'(load_gd_wr_addr[c]) != e.addr || load_gd_din[c] != e.data) ok = 0;
                        end else begin
                            if (int'(load_fm_wr_addr[c]) != e.addr || load_fm_din[c] != e.data) ok = 0;
                        end
                    end
                end
                if (!ok) begin
                    errors++;
                    $display("FAIL write: got fm_en=%b gd_en=%b fm_addr=%h gd_addr=%h, required tgt=%0d mask=%b addr=%0d data=%h",
                             load_fm_wr_en, load_gd_wr_en, load_fm_wr_addr, load_gd_wr_addr,
                             e.tgt, e.mask, e.addr, e.data);
                end
            end
        end
        exp_done = zero_len_due || (in_cmd && wrote && exp_q.size() == 0);
        checks++;
        if (load_done !== exp_done) begin
            errors++;
            $display("FAIL done_timing: load_done=%b, required %b", load_done, exp_done);
        end
        if (load_done) begin
            in_cmd    = 0;
            done_seen = 1;
        end
        zero_len_due = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input bit tgt, input bit bc, input logic [7:0] cn,
                             input logic [15:0] base, input logic [15:0] words);
        int g;
        build_model(tgt, bc, cn, base, words);
        wr_cycles   = 0;
        done_seen   = 0;
        cmd_valid   = 1'b1;
        cmd_target  = tgt;
        cmd_bcast   = bc;
        cmd_col_num = cn;
        cmd_base    = base;
        cmd_words   = words;
        g = 0;
        while (!cmd_ready && g < 20) begin
            step();
            check_cycle();
            g++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b, required 1", cmd_ready);
        end
        zero_len_due = (words == 0) || (cn == 0);
        in_cmd       = !zero_len_due;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (!(load_busy && !cmd_ready)) begin
            errors++;
            $display("FAIL busy_after_accept: busy=%b cmd_ready=%b, required 1/0", load_busy, cmd_ready);
        end
        check_cycle();
    endtask

    // Stream queued data; gap<0 random valid, gap=k gives 1 on / k off
    task automatic stream(input int gap, input int max_hs);
        int hs_done;
        int guard;
        int phase;
        bit want;
        bit hs;
        hs_done = 0;
        guard   = 0;
        phase   = 0;
        while (!done_seen && hs_done < max_hs && guard < 400) begin
            if (gap < 0) want = ($urandom_range(0, 2) == 0);
            else         want = (phase == 0);
            phase   = (gap <= 0) ? 0 : (phase + 1) % (gap + 1);
            s_valid = want && (data_q.size() > 0);
            s_data  = (data_q.size() > 0) ? data_q[0] : 72'd0;
            hs      = s_valid && s_ready;
            step();
            if (hs) begin
                void'(data_q.pop_front());
                hs_done++;
            end
            s_valid = 1'b0;
            check_cycle();
            guard++;
        end
    endtask

    task automatic run_cmd(input bit tgt, input bit bc, input logic [7:0] cn,
                           input logic [15:0] base, input logic [15:0] words,
                           input int gap, input int exp_wr, input string name);
        int need;
        issue_cmd(tgt, bc, cn, base, words);
        need = (exp_wr >= 0) ? exp_wr : model_n;
        stream(gap, 1 << 20);
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s done_timeout: load_done never seen, required a pulse", name);
            in_cmd = 0;
        end
        checks++;
        if (wr_cycles != need || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s write_count: got %0d cycles (%0d unmatched), required %0d",
                     name, wr_cycles, exp_q.size(), need);
        end
        step();
        check_cycle();
        checks++;
        if (!(cmd_ready && !load_busy && !s_ready)) begin
            errors++;
            $display("FAIL %s idle_after_done: cmd_ready=%b busy=%b s_ready=%b, required 1/0/0",
                     name, cmd_ready, load_busy, s_ready);
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 8'd2,   16'h0010, 16'd3, 0, 6};   // basic sequential
        tbl[1] = '{1'b1, 1'b1, 8'd4,   16'h0000, 16'd4, 0, 4};   // GD broadcast
        tbl[2] = '{1'b0, 1'b0, 8'd2,   16'h0000, 16'd5, 2, 10};  // 1 on / 2 off stalls
        tbl[3] = '{1'b0, 1'b0, 8'd1,   16'd62,   16'd4, 0, 4};   // FM wrap
        tbl[4] = '{1'b0, 1'b0, 8'd255, 16'h0000, 16'd2, 0, 8};   // clamp
        tbl[5] = '{1'b0, 1'b1, 8'd255, 16'h0005, 16'd3, 0, 3};   // clamp bcast
        tbl[6] = '{1'b1, 1'b0, 8'd0,   16'h0000, 16'd5, 0, 0};   // zero columns
        tbl[7] = '{1'b0, 1'b0, 8'd3,   16'h0000, 16'd0, 0, 0};   // zero words
        tbl[8] = '{1'b1, 1'b0, 8'd4,   16'd30,   16'd3, 1, 12};  // GD wrap, stalls
        tbl[9] = '{1'b1, 1'b1, 8'd2,   16'hFFFF, 16'd2, 0, 2};   // base truncation

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_target  = 1'b0;
        cmd_bcast   = 1'b0;
        cmd_col_num = 8'd0;
        cmd_base    = 16'd0;
        cmd_words   = 16'd0;
        s_valid     = 1'b0;
        s_data      = 72'd0;

        // Reset state
        repeat (3) step();
        checks++;
        if (load_fm_wr_en != 0 || load_gd_wr_en != 0 || load_fm_wr_addr != 0 || load_gd_wr_addr != 0 ||
            load_fm_din != 0 || load_gd_din != 0 || load_busy || load_done || s_ready) begin
            errors++;
            $display("FAIL reset_values: fm_en=%b gd_en=%b busy=%b done=%b s_ready=%b, required all zero",
                     load_fm_wr_en, load_gd_wr_en, load_busy, load_done, s_ready);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_ready_after_reset: got %b, required 1", cmd_ready);
        end

        // Data presented while idle must be ignored
        s_valid = 1'b1;
        s_data  = {8'hAA, $urandom, $urandom};
        for (int k = 0; k < 3; k++) begin
            step();
            check_cycle();
            checks++;
            if (s_ready) begin
                errors++;
                $display("FAIL s_ready_idle: got %b, required 0", s_ready);
            end
        end
        s_valid = 1'b0;

        // Table-driven commands
        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i].tgt, tbl[i].bcast, tbl[i].cn, tbl[i].base, tbl[i].words,
                    tbl[i].gap, tbl[i].exp_wr, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a 2x3 load after two words
        issue_cmd(1'b0, 1'b0, 8'd2, 16'h0010, 16'd3);
        stream(0, 2);
        rst_n = 1'b0;
        exp_q.delete();
        data_q.delete();
        in_cmd = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_cycle();
        end
        rst_n = 1'b1;
        step();
        check_cycle();
        checks++;
        if (!(cmd_ready && !load_busy && !s_ready)) begin
            errors++;
            $display("FAIL abort_idle: cmd_ready=%b busy=%b s_ready=%b, required 1/0/0",
                     cmd_ready, load_busy, s_ready);
        end
        run_cmd(1'b0, 1'b0, 8'd2, 16'h0010, 16'd3, 0, 6, "after_abort");

        // Randomized commands against the model
        for (int r = 0; r < 24; r++) begin
            run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 6)), 16'($urandom), 16'($urandom_range(0, 5)),
                    int'($urandom_range(0, 3)) - 1, -1, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/diff_fm_loader.md
# diff_fm_loader

Upstream load stage for the diff core. It accepts a load command and a 72-bit word stream over valid/ready handshakes. It scatters the words into the per-column feature-map (FM) or guard (GD) buffer write ports of the core: `load_fm_*` / `load_gd_*`. Writes are column-sequential, or broadcast to several columns, and a one-cycle done pulse is raised when the command completes.

## Interface
Parameters:
- `NUM_COL`, default `CONF_PE_COL`: number of PE columns / buffer ports.
- `FM_DEPTH`, default `CONF_FM_BUF_DEPTH`: FM buffer depth; `FAW = $clog2(FM_DEPTH)`.
- `GD_DEPTH`, default `CONF_GUARD_BUF_DEPTH`: guard buffer depth; `GAW = $clog2(GD_DEPTH)`.

Ports (clock and reset first):
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `cmd_valid`, in, 1: command valid.
- `cmd_ready`, out, 1: command accepted when high with `cmd_valid`.
- `cmd_target`, in, 1: 0 = FM, 1 = GD.
- `cmd_bcast`, in, 1: 1 = every word goes to all active columns.
- `cmd_col_num`, in, 8: active columns (0 .. `cmd_col_num`-1).
- `cmd_base`, in, 16: start address; truncated to `FAW`/`GAW` bits.
- `cmd_words`, in, 16: words per column.
- `s_valid`, in, 1: data valid.
- `s_ready`, out, 1: data accepted when high with `s_valid`.
- `s_data`, in, 72: data word.
- `load_fm_wr_addr`, out, `[NUM_COL][FAW]`: FM write address per column.
- `load_fm_din`, out, `[NUM_COL][72]`: FM write data per column.
- `load_fm_wr_en`, out, `[NUM_COL]`: FM write enable per column.
- `load_gd_wr_addr`, out, `[NUM_COL][GAW]`: GD write address per column.
- `load_gd_din`, out, `[NUM_COL][72]`: GD write data per column.
- `load_gd_wr_en`, out, `[NUM_COL]`: GD write enable per column.
- `load_busy`, out, 1: high whenever state ≠ IDLE.
- `load_done`, out, 1: one-cycle pulse at command completion.

## Operation
- States: IDLE, LOAD, DONE.
- **IDLE**
  - `cmd_ready`=1, `s_ready`=0.
  - On `cmd_valid`, latch all `cmd_*` fields.
  - `cmd_col_num` is clamped to `NUM_COL`; this clamp applies after the zero check below.
  - If `cmd_words`=0 or `cmd_col_num`=0, go to DONE; no writes occur.
  - Otherwise clear `col_cnt` and `word_cnt`, set `addr`=base, and go to LOAD.
- **LOAD**
  - `s_ready`=1, `cmd_ready`=0.
  - Each handshake writes `s_data` at `addr` into the target buffer only.
  - Non-bcast: the word goes to column `col_cnt` only.
  - Bcast: the word goes to columns 0..col_num-1 simultaneously.
  - Per handshake, `word_cnt`++ and `addr`++. Address wraps modulo 2^FAW / 2^GAW by natural truncation; no error is raised.
  - When `word_cnt`=words-1:
    - Non-bcast, `col_cnt`<col_num-1: `word_cnt`→0, `addr`→base, `col_cnt`++.
    - Non-bcast, last column: go to DONE.
    - Bcast: go to DONE.
  - Total handshakes: words×col_num (non-bcast) or words (bcast).
- **DONE**
  - `load_done`=1 for exactly one cycle, then return to IDLE.
  - `cmd_ready`=0 and `s_ready`=0.
- Gaps in `s_valid` stall the load with no side effects. Data with `s_valid` in IDLE/DONE is not accepted.
- The unused target's `wr_en` stays 0 throughout the command.

## Timing
- Write outputs (`*_wr_addr`, `*_din`, `*_wr_en`) are registered: a handshake in cycle N produces the write in cycle N+1.
  - `wr_en` is a single-cycle pulse per handshake.
  - `addr`/`din` hold their last value when `wr_en`=0.
- `load_done` coincides with the last write's `wr_en` cycle. For zero-length commands it comes 1 cycle after command acceptance.
- Earliest next command: the cycle after `load_done`.
- Throughput: one word per cycle with `s_valid` held high. `s_ready` is a registered state decode with no combinational path from `s_valid`.
- Reset values (rst_n=0 at a clock edge):
  - State IDLE, all counters 0.
  - All `wr_en`=0, `*_wr_addr`=0, `*_din`=0.
  - `load_busy`=0, `load_done`=0, `s_ready`=0.
  - `cmd_ready`=1 from the first cycle after release.
- Reset mid-LOAD aborts immediately: no further writes, no `load_done`. Already-written words remain in the buffers.

## Structure
- `diff_demo_pkg` gains:
  - `typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DONE} load_state_e;`
  - `localparam LD_TGT_FM = 1'b0, LD_TGT_GD = 1'b1;`
- `CONF_*` depth/column constants are reused from the package.
- One natural sub-module: `load_col_decoder`. It combinationally maps (`col_cnt`, `col_num`, `bcast`, `fire`) to a `NUM_COL`-bit one-hot or thermometer enable vector.

## Test plan
- Reset to a non-bcast load:
  - Stimulus: after reset, FM command with col_num=2, base=0x10, words=3; data D0..D5 streamed back-to-back.
  - Required: col0 receives 0x10..0x12 = D0..D2 and col1 receives 0x10..0x12 = D3..D5. `load_done` coincides with the D5 write. 6 `wr_en` pulses total; GD `wr_en` never asserted.
- GD broadcast:
  - Stimulus: GD command with bcast=1, col_num=`NUM_COL`, base=0, words=4.
  - Required: each word is written to all columns at the same address 0..3. 4 write cycles, then done.
- Stalls:
  - Stimulus: random `s_valid` gaps (e.g. 1 on / 2 off) during a 2×5 FM load.
  - Required: results identical to the back-to-back case; no `wr_en` during gaps.
- Wrap and clamp:
  - Stimulus: base=FM_DEPTH-2, words=4.
  - Required: addresses FM_DEPTH-2, FM_DEPTH-1, 0, 1.
  - Stimulus: col_num=255.
  - Required: treated as `NUM_COL`.
- Zero length:
  - Stimulus: words=0.
  - Required: done 1 cycle after acceptance, no writes.
- Reset mid-LOAD:
  - Stimulus: assert rst_n=0 after 2 of 6 words.
  - Required: no more writes, no `load_done`, `cmd_ready`=1 after release. A new command then runs correctly from word 0.
